// File: rtl/div8b_seq_if.sv
// Bundle of the divider's request/result handshake and the shared sub8b subtractor port.
// The slave modport is the divider side; the master modport is the requester/subtractor side.
interface div8b_seq_if #(
    parameter int DATASIZE = 8
);
    logic                iStart;
    logic [DATASIZE-1:0] iDividend;
    logic [DATASIZE-1:0] iDivisor;
    logic [DATASIZE-1:0] oSubJ;
    logic [DATASIZE-1:0] oSubK;
    logic [DATASIZE-1:0] oSubB;
    logic [DATASIZE-1:0] iSubD;
    logic                iSubB;
    logic                oBusy;
    logic                oDone;
    logic [DATASIZE-1:0] oQuot;
    logic [DATASIZE-1:0] oRem;
    logic                oDivZero;

    modport slave (
        input  iStart, iDividend, iDivisor, iSubD, iSubB,
        output oSubJ, oSubK, oSubB, oBusy, oDone, oQuot, oRem, oDivZero
    );

    modport master (
        output iStart, iDividend, iDivisor, iSubD, iSubB,
        input  oSubJ, oSubK, oSubB, oBusy, oDone, oQuot, oRem, oDivZero
    );
endinterface

// File: rtl/div8b_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, using an external
// shared subtractor (sub8b) whose operands come straight from registers.
module div8b_seq #(
    parameter int DATASIZE = 8
) (
    input  logic       iClock,
    input  logic       iReset,
    div8b_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int CW = $clog2(DATASIZE + 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [DATASIZE-1:0] r_q;
    logic [DATASIZE-1:0] q_q;
    logic [DATASIZE-1:0] div_q;
    logic [DATASIZE-1:0] quot_q;
    logic [DATASIZE-1:0] rem_q;
    logic                busy_q;
    logic                done_q;
    logic                dz_q;

    logic [DATASIZE:0]   shift;
    logic                accept;
    logic [DATASIZE-1:0] r_d;
    logic [DATASIZE-1:0] q_d;

    // One restoring step. The subtractor sees only registered values, so the loop through
    // sub8b is a single combinational pass back into r_d.
    always_comb begin
        // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
        shift  = {r_q, q_q[DATASIZE-1]};
        accept = shift[DATASIZE] | ~bus.iSubB;
        r_d    = accept ? bus.iSubD : shift[DATASIZE-1:0];
        q_d    = {q_q[DATASIZE-2:0], accept};
    end

    assign bus.oSubJ    = shift[DATASIZE-1:0];
    assign bus.oSubK    = div_q;
    assign bus.oSubB    = '0;
    assign bus.oBusy    = busy_q;
    assign bus.oDone    = done_q;
    assign bus.oQuot    = quot_q;
    assign bus.oRem     = rem_q;
    assign bus.oDivZero = dz_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iStart) begin
                        div_q <= bus.iDivisor;
                        q_q   <= bus.iDividend;
                        r_q   <= '0;
                        cnt_q <= '0;
                        if (bus.iDivisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= bus.iDividend;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DATASIZE - 1)) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div8b_seq.sv
// Directed bench for div8b_seq with a behavioural sub8b bound to the subtractor port;
// checks results, latency, busy length, start blocking, reset abort and a sampled sweep.
module tb_div8b_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div8b_seq_if #(.DATASIZE(8)) bus ();

    div8b_seq #(.DATASIZE(8)) dut (
        .iClock (clk),
        .iReset (rst_n),
        .bus    (bus)
    );

    // Behavioural sub8b: 9-bit difference, MSB is the borrow-out.
    assign {bus.iSubB, bus.iSubD} = {1'b0, bus.oSubJ} - {1'b0, bus.oSubK};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one divide at the current negedge and check everything about it.
    // inj_at > 0 pulses a competing start with other operands in that RUN cycle.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int inj_at);
        int         n;
        int         busy_n;
        bit         seen;
        logic [7:0] eq;
        logic [7:0] er;
        eq = (b == 8'd0) ? 8'hFF : a / b;
        er = (b == 8'd0) ? a : a % b;
        bus.iStart    = 1'b1;
        bus.iDividend = a;
        bus.iDivisor  = b;
        @(negedge clk);
        bus.iStart    = 1'b0;
        bus.iDividend = ~a;
        bus.iDivisor  = 8'h5A;
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (n <= 20 && !seen) begin
            if (bus.oDone) begin
                seen = 1'b1;
            end else begin
                if (bus.oBusy) busy_n++;
                if (n == inj_at) begin
                    bus.iStart    = 1'b1;
                    bus.iDividend = 8'd50;
                    bus.iDivisor  = 8'd5;
                end else begin
                    bus.iStart = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        bus.iStart = 1'b0;
        check($sformatf("done_seen %0d/%0d", a, b), 32'(seen), 32'd1);
        check($sformatf("latency %0d/%0d", a, b), n, (b == 8'd0) ? 32'd1 : 32'd9);
        check($sformatf("busy_len %0d/%0d", a, b), busy_n, (b == 8'd0) ? 32'd0 : 32'd8);
        check($sformatf("quot %0d/%0d", a, b), 32'(bus.oQuot), 32'(eq));
        check($sformatf("rem %0d/%0d", a, b), 32'(bus.oRem), 32'(er));
        check($sformatf("divzero %0d/%0d", a, b), 32'(bus.oDivZero), 32'(b == 8'd0));
        check($sformatf("busy_at_done %0d/%0d", a, b), 32'(bus.oBusy), 32'd0);
        @(negedge clk);
        check($sformatf("done_pulse_end %0d/%0d", a, b), 32'(bus.oDone), 32'd0);
        check($sformatf("no_restart %0d/%0d", a, b), 32'(bus.oBusy), 32'd0);
        check($sformatf("quot_held %0d/%0d", a, b), 32'(bus.oQuot), 32'(eq));
    endtask

    initial begin
        int  n;
        bit  seen;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.iStart    = 1'b1;
        bus.iDividend = 8'd100;
        bus.iDivisor  = 8'd7;
        repeat (3) @(negedge clk);

        // Reset dominates a pending start.
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_done", 32'(bus.oDone), 32'd0);
        check("rst_quot", 32'(bus.oQuot), 32'd0);
        check("rst_rem", 32'(bus.oRem), 32'd0);
        check("rst_divzero", 32'(bus.oDivZero), 32'd0);
        check("rst_subj", 32'(bus.oSubJ), 32'd0);
        check("rst_subk", 32'(bus.oSubK), 32'd0);
        check("subb_zero", 32'(bus.oSubB), 32'd0);
        bus.iStart = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);

        run_div(8'd100, 8'd7, 0);
        run_div(8'd250, 8'd200, 0);
        run_div(8'd255, 8'd128, 0);
        run_div(8'd200, 8'd255, 0);
        run_div(8'd255, 8'd1, 0);
        run_div(8'd5, 8'd0, 0);
        run_div(8'd9, 8'd3, 0);
        run_div(8'd0, 8'd9, 0);
        run_div(8'd100, 8'd7, 3);

        // Held start: back-to-back divides, done pulses 10 cycles apart.
        bus.iStart    = 1'b1;
        bus.iDividend = 8'd12;
        bus.iDivisor  = 8'd5;
        n    = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            seen = bus.oDone;
        end
        check("held_first_done", 32'(seen), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            seen = bus.oDone;
        end
        bus.iStart = 1'b0;
        check("held_second_done", 32'(seen), 32'd1);
        check("held_gap", n, 32'd10);
        check("held_quot", 32'(bus.oQuot), 32'd2);
        check("held_rem", 32'(bus.oRem), 32'd2);
        repeat (2) @(negedge clk);

        // Reset in cycle 4 of RUN aborts the divide without a done pulse.
        bus.iStart    = 1'b1;
        bus.iDividend = 8'd200;
        bus.iDivisor  = 8'd3;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(bus.oBusy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.oBusy), 32'd0);
        check("abort_done", 32'(bus.oDone), 32'd0);
        check("abort_quot", 32'(bus.oQuot), 32'd0);
        check("abort_rem", 32'(bus.oRem), 32'd0);
        check("abort_divzero", 32'(bus.oDivZero), 32'd0);
        check("abort_subj", 32'(bus.oSubJ), 32'd0);
        check("abort_subk", 32'(bus.oSubK), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.oDone || bus.oBusy) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_div(8'd17, 8'd4, 0);

        // Sampled sweep against reference arithmetic, including zero divisors.
        for (int i = 0; i < 120; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (i % 5 == 0) b = 8'($urandom_range(1, 7));
            run_div(a, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
